// File: rtl/uart_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Brief    : Register map, bit indices and RX FSM encoding for uart_rx_periph.
//            The PARITY state exists only when UART_RX_PARITY_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam logic [1:0] UART_RXDATA = 2'd0;
    localparam logic [1:0] UART_STATUS = 2'd1;
    localparam logic [1:0] UART_CTRL   = 2'd2;

    localparam int STAT_NOT_EMPTY  = 0;
    localparam int STAT_FULL       = 1;
    localparam int STAT_OVERRUN    = 2;
    localparam int STAT_FRAME_ERR  = 3;
    localparam int STAT_PARITY_ERR = 4;

    localparam int CTRL_RX_EN  = 0;
    localparam int CTRL_IRQ_EN = 1;

    localparam logic [1:0] CTRL_RESET = 2'b01;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        RX_PARITY = 3'd3,
`endif
        RX_STOP   = 3'd4
    } rx_state_e;

    // Even parity: the parity bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock first-word-fall-through FIFO. A push into a full FIFO
//            is accepted when a pop happens in the same cycle.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

`default_nettype wire

// File: rtl/uart_rx_periph.sv
// ============================================================================
// Module   : uart_rx_periph
// Brief    : Memory-mapped UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN)
//            feeding an RX FIFO, with RXDATA/STATUS/CTRL registers and an IRQ.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_rx_periph #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        enable_i,
    input  logic        load_enable_i,
    input  logic        store_enable_i,
    input  logic [3:0]  address_i,
    input  logic [31:0] data_i,
    input  logic        uart_rxd_i,
    output logic [31:0] data_o,
    output logic        irq_o
);

    import uart_pkg::*;

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    // Line synchroniser and previous-sample register for edge detection.
    logic rxd_meta;
    logic rxd_sync;
    logic rxd_prev;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_meta <= uart_rxd_i;
            rxd_sync <= rxd_meta;
            rxd_prev <= rxd_sync;
        end
    end

    logic [1:0] ctrl;
    logic       rx_en;
    logic       irq_en;

    assign rx_en  = ctrl[CTRL_RX_EN];
    assign irq_en = ctrl[CTRL_IRQ_EN];

    rx_state_e       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [7:0]      shreg, shreg_n;
    logic [2:0]      bit_idx, bit_n;
    logic            push_req;
    logic            set_frame;
    logic            set_parity;
`ifdef UART_RX_PARITY_EN
    logic            parity_bad, parity_bad_n;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= RX_IDLE;
            cnt     <= '0;
            shreg   <= '0;
            bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
            parity_bad <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            shreg   <= shreg_n;
            bit_idx <= bit_n;
`ifdef UART_RX_PARITY_EN
            parity_bad <= parity_bad_n;
`endif
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        shreg_n    = shreg;
        bit_n      = bit_idx;
        push_req   = 1'b0;
        set_frame  = 1'b0;
        set_parity = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_bad_n = parity_bad;
`endif
        if (!rx_en) begin
            state_n = RX_IDLE;
            cnt_n   = '0;
        end else begin
            case (state)
                RX_IDLE: begin
                    if (rxd_prev && !rxd_sync) begin
                        state_n = RX_START;
                        cnt_n   = '0;
                    end
                end
                RX_START: begin
                    if (cnt == CNT_HALF) begin
                        cnt_n   = '0;
                        bit_n   = '0;
                        state_n = rxd_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt_n   = '0;
                        shreg_n = {rxd_sync, shreg[7:1]};
                        bit_n   = bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_n = RX_PARITY;
`else
                            state_n = RX_STOP;
`endif
                        end
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                RX_PARITY: begin
                    if (cnt == CNT_LAST) begin
                        cnt_n        = '0;
                        parity_bad_n = rxd_sync ^ even_parity(shreg);
                        state_n      = RX_STOP;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
`endif
                RX_STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt_n   = '0;
                        state_n = RX_IDLE;
                        if (rxd_sync) begin
                            push_req = 1'b1;
`ifdef UART_RX_PARITY_EN
                            set_parity = parity_bad;
`endif
                        end else begin
                            set_frame = 1'b1;
                        end
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
                default: state_n = RX_IDLE;
            endcase
        end
    end

    // One bus instruction holds its strobes for several cycles; act on the rising edge only.
    logic load_now, store_now;
    logic load_q, store_q;
    logic load_fire, store_fire;
    logic [1:0] reg_sel;

    assign load_now   = enable_i & load_enable_i;
    assign store_now  = enable_i & store_enable_i;
    assign load_fire  = load_now & ~load_q;
    assign store_fire = store_now & ~store_q;
    assign reg_sel    = address_i[3:2];

    logic [7:0]                  fifo_rdata;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                        fifo_pop;
    logic                        set_overrun;

    assign fifo_pop    = load_fire & (reg_sel == UART_RXDATA) & ~fifo_empty;
    assign set_overrun = push_req & fifo_full & ~fifo_pop;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .push  (push_req),
        .pop   (fifo_pop),
        .wdata (shreg),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    logic overrun;
    logic frame_err;
    logic parity_err;
    logic clr_status;

    assign clr_status = store_fire & (reg_sel == UART_STATUS);

`ifdef UART_RX_PARITY_EN
    logic parity_err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) parity_err_q <= 1'b0;
        else         parity_err_q <= set_parity |
                                     (parity_err_q & ~(clr_status & data_i[STAT_PARITY_ERR]));
    end

    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    logic [31:0] rd_data;

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            UART_RXDATA: if (!fifo_empty) rd_data = {23'b0, 1'b1, fifo_rdata};
            UART_STATUS: rd_data = {27'b0, parity_err, frame_err, overrun, fifo_full, ~fifo_empty};
            UART_CTRL:   rd_data = {30'b0, ctrl};
            default:     rd_data = '0;
        endcase
    end

    // A set in the same cycle as a write-1-to-clear wins.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            load_q    <= 1'b0;
            store_q   <= 1'b0;
            ctrl      <= CTRL_RESET;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            data_o    <= '0;
            irq_o     <= 1'b0;
        end else begin
            load_q    <= load_now;
            store_q   <= store_now;
            overrun   <= set_overrun | (overrun & ~(clr_status & data_i[STAT_OVERRUN]));
            frame_err <= set_frame | (frame_err & ~(clr_status & data_i[STAT_FRAME_ERR]));
            if (store_fire && reg_sel == UART_CTRL) ctrl <= data_i[1:0];
            if (load_fire) data_o <= rd_data;
            irq_o <= irq_en & (~fifo_empty | overrun | frame_err | parity_err);
        end
    end

    logic unused_bits;
    assign unused_bits = ^{address_i[1:0], data_i[31:4], data_i[1:0], fifo_count, set_parity};

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_periph.sv
// ============================================================================
// Module   : tb_uart_rx_periph
// Brief    : Scoreboard bench for uart_rx_periph: frames are serialised on the
//            line, expected bytes queued, and compared on RXDATA reads.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_rx_periph;

    localparam int CPB   = 8;
    localparam int DEPTH = 4;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        enable   = 1'b0;
    logic        load_en  = 1'b0;
    logic        store_en = 1'b0;
    logic [3:0]  addr     = '0;
    logic [31:0] wdata    = '0;
    logic        rxd      = 1'b1;
    logic [31:0] rdata;
    logic        irq;

    always #5 clk = ~clk;

    uart_rx_periph #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .enable_i       (enable),
        .load_enable_i  (load_en),
        .store_enable_i (store_en),
        .address_i      (addr),
        .data_i         (wdata),
        .uart_rxd_i     (rxd),
        .data_o         (rdata),
        .irq_o          (irq)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] sb_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic bus_read(input logic [3:0] a, input int hold, output logic [31:0] d);
        @(negedge clk);
        addr = a; enable = 1'b1; load_en = 1'b1;
        repeat (hold) @(negedge clk);
        d = rdata;
        enable = 1'b0; load_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a; wdata = d; enable = 1'b1; store_en = 1'b1;
        @(negedge clk);
        enable = 1'b0; store_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_reg(input string tag, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] v;
        bus_read(a, 1, v);
        check(tag, v, exp);
    endtask

    task automatic read_rx(input string tag, input int hold);
        logic [31:0] v;
        logic [31:0] exp;
        exp = '0;
        if (sb_q.size() > 0) exp = {23'b0, 1'b1, sb_q.pop_front()};
        bus_read(4'h0, hold, v);
        check(tag, v, exp);
    endtask

    task automatic drive_bit(input logic v);
        rxd = v;
        repeat (CPB) @(negedge clk);
    endtask

    // A frame with a good stop bit lands in the FIFO unless it is already full.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        if (stop && sb_q.size() < DEPTH) sb_q.push_back(b);
        @(negedge clk);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(^b);
`endif
        drive_bit(stop);
        rxd = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_data_o", rdata, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_reg("reset_ctrl", 4'h8, 32'h1);
        check_reg("reset_status", 4'h4, 32'h0);

        send_frame(8'hA5, 1'b1);
        check_reg("a5_status", 4'h4, 32'h1);
        read_rx("a5_rxdata", 1);
        read_rx("a5_empty", 1);

        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        read_rx("hold_rxdata", 5);
        check_reg("hold_status", 4'h4, 32'h1);
        read_rx("hold_second", 1);

        for (int i = 0; i < DEPTH + 1; i++) send_frame(8'h30 + 8'(i), 1'b1);
        check_reg("ovr_status", 4'h4, 32'h7);
        bus_write(4'h4, 32'h4);
        check_reg("ovr_cleared", 4'h4, 32'h3);
        for (int i = 0; i < DEPTH; i++) read_rx("ovr_drain", 1);
        check_reg("ovr_final_status", 4'h4, 32'h0);

        bus_write(4'h8, 32'h3);
        check("ferr_irq_idle", {31'b0, irq}, 32'h0);
        send_frame(8'h3C, 1'b0);
        check_reg("ferr_status", 4'h4, 32'h8);
        check("ferr_irq", {31'b0, irq}, 32'h1);
        bus_write(4'h4, 32'h8);
        @(negedge clk);
        check("ferr_irq_clr", {31'b0, irq}, 32'h0);
        check_reg("ferr_status_clr", 4'h4, 32'h0);
        bus_write(4'h8, 32'h1);

        @(negedge clk);
        rxd = 1'b0;
        repeat (2) @(negedge clk);
        rxd = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check_reg("glitch_status", 4'h4, 32'h0);
        read_rx("glitch_empty", 1);

        bus_write(4'h8, 32'h3);
        check_reg("ctrl_written", 4'h8, 32'h3);
        @(negedge clk);
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mid_data_o", rdata, 32'h0);
        check("rst_mid_irq", {31'b0, irq}, 32'h0);
        rxd = 1'b1;
        rst_n = 1'b1;
        repeat (4 * CPB) @(negedge clk);
        check_reg("rst_mid_ctrl", 4'h8, 32'h1);
        check_reg("rst_mid_status", 4'h4, 32'h0);
        send_frame(8'h5A, 1'b1);
        read_rx("rst_mid_rxdata", 1);
        read_rx("rst_mid_empty", 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
